// File: rtl/split_word_load.sv
// Load-side extractor for the MEM stage: issues one word-aligned read per request and
// returns the addressed byte/half/word, sign- or zero-extended, with error pulses.
module split_word_load #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   input  logic [31:0] load_addr,
   input  logic [2:0]  load_type,
   output logic        load_ready,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        load_misaligned,
   output logic        load_timeout
);

   localparam logic [2:0] T_LB  = 3'd0;
   localparam logic [2:0] T_LBU = 3'd1;
   localparam logic [2:0] T_LH  = 3'd2;
   localparam logic [2:0] T_LHU = 3'd3;
   localparam logic [2:0] T_LW  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         off_q, off_d;
   logic [2:0]         type_q, type_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic               mem_re_q, mem_re_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        load_data_q, load_data_d;
   logic               load_valid_q, load_valid_d;
   logic               mis_q, mis_d;
   logic               tmo_q, tmo_d;

   // Illegal types and addresses not naturally aligned for the access size are rejected.
   function automatic logic req_bad(input logic [1:0] k, input logic [2:0] t);
      logic bad;
      case (t)
         T_LB, T_LBU: bad = 1'b0;
         T_LH, T_LHU: bad = k[0];
         T_LW:        bad = (k != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic signed [31:0] extract(input logic [31:0] word,
                                                  input logic [1:0]  k,
                                                  input logic [2:0]  t);
      logic [7:0]         b;
      logic [15:0]        h;
      logic signed [31:0] r;
      case (k)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = k[1] ? word[31:16] : word[15:0];
      case (t)
         T_LB:    r = {{24{b[7]}}, b};
         T_LBU:   r = {24'd0, b};
         T_LH:    r = {{16{h[15]}}, h};
         T_LHU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         off_q        <= 2'd0;
         type_q       <= 3'd0;
         mem_addr_q   <= 32'd0;
         mem_re_q     <= 1'b0;
         cnt_q        <= '0;
         load_data_q  <= 32'd0;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         type_q       <= type_d;
         mem_addr_q   <= mem_addr_d;
         mem_re_q     <= mem_re_d;
         cnt_q        <= cnt_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mis_q        <= mis_d;
         tmo_q        <= tmo_d;
      end
   end

   // Pulse outputs are registered on the transition edge so they line up with RESP/ERR.
   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      type_d       = type_q;
      mem_addr_d   = mem_addr_q;
      mem_re_d     = 1'b0;
      cnt_d        = cnt_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      mis_d        = 1'b0;
      tmo_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_req) begin
               off_d      = load_addr[1:0];
               type_d     = load_type;
               mem_addr_d = {load_addr[31:2], 2'b00};
               if (req_bad(load_addr[1:0], load_type)) begin
                  state_d = S_ERR;
                  mis_d   = 1'b1;
               end else begin
                  state_d  = S_REQ;
                  mem_re_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem_rvalid) begin
               state_d      = S_RESP;
               load_data_d  = extract(mem_rdata, off_q, type_q);
               load_valid_d = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d      = S_RESP;
               load_data_d  = extract(mem_rdata, off_q, type_q);
               load_valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign load_ready      = (state_q == S_IDLE);
   assign mem_re          = mem_re_q;
   assign mem_addr        = mem_addr_q;
   assign load_data       = load_data_q;
   assign load_valid      = load_valid_q;
   assign load_misaligned = mis_q;
   assign load_timeout    = tmo_q;

endmodule
